oled_iic_arb: RTL
=================

# oled_iic_arb

Parametrised N-channel request arbiter between the OLED command sources (init, clear, char, and future sources such as scroll or contrast) and the single IIC byte-transfer engine. It replaces the combinational priority select with a registered, grant-locked transaction arbiter. It captures the winning channel's data word, holds it stable for the whole IIC transfer, and returns a per-channel completion acknowledge. Channel 0 has the highest priority by default; round-robin is available as a build option.

## Interface
- `N_CH`, default 3: number of requesting channels (index 0 = init, 1 = clear, 2 = char). Legal range 2..8.
- `DW`, default 24: data word width per channel (device addr, control byte, payload byte).
- `clk_50m`, input, 1: system clock. One clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `i_req`, input, `N_CH`: per-channel request level. Held high until the matching `o_ack` pulse.
- `i_data`, input, `N_CH*DW`: channel k data is at bits `[k*DW +: DW]`. Must be stable while `i_req[k]` is high.
- `o_ack`, output, `N_CH`: one-cycle pulse to the served channel when its transfer completes.
- `o_grant`, output, `N_CH`: one-hot grant, held from capture until the ack cycle inclusive.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_iic_req`, output, 1: one-cycle start pulse to the IIC engine.
- `o_iic_data`, output, `DW`: registered transfer word, stable from the ISSUE cycle through the ACK cycle.
- `i_iic_done`, input, 1: one-cycle pulse from the IIC engine when the transfer completes.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If `i_req` is nonzero, select the winner, latch its `i_data` slice into `o_iic_data`, set `o_grant`, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: `o_iic_req`=1 for exactly this cycle, then go to WAIT.
- WAIT: hold until `i_iic_done`=1, then go to ACK. `i_iic_done` is ignored in IDLE, ISSUE and ACK.
- ACK: `o_ack[grant]`=1 for one cycle, then clear `o_grant` and return to IDLE.
- Selection in the default build is fixed priority: lowest set index of `i_req` wins.
- Grant is locked for the whole transaction:
  - A higher-priority request arriving in ISSUE, WAIT or ACK waits for the next IDLE.
  - The granted channel dropping `i_req` mid-transaction does not abort. The transfer completes and `o_ack` still pulses.
- A requester still holding `i_req` in the cycle after its ack is treated as a new request in IDLE.
- `o_iic_data` keeps its last value in IDLE. Only a capture in IDLE updates it.
- The `i_data` slice is indexed with a width of `$clog2(N_CH)` bits. Unused encodings cannot occur because the grant is one-hot.

## Timing
- Reset values: state=IDLE, `o_ack`=0, `o_grant`=0, `o_busy`=0, `o_iic_req`=0, `o_iic_data`=0, round-robin pointer=`N_CH-1`.
- Reset mid-transaction returns to IDLE immediately. No ack is issued.
- Request seen in IDLE at cycle t:
  - ISSUE at t+1, with `o_iic_req`=1 and `o_iic_data` valid.
  - WAIT from t+2.
- `i_iic_done` at cycle d (in WAIT): ACK at d+1 with `o_ack` pulsed; IDLE at d+2.
- Minimum transaction length: 4 cycles, so back-to-back channel service is one transfer per 4 cycles plus the IIC time.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `OLED_ARB_RR_EN` undefined: fixed priority, index 0 highest.
- `OLED_ARB_RR_EN` defined: round-robin.
  - A pointer holds the last granted index and updates in the ACK cycle.
  - In IDLE the search starts at pointer+1 and wraps modulo `N_CH`. The first set request wins.
  - After reset the pointer is `N_CH-1`, so channel 0 wins first.
- The FSM, handshake and timing are identical in both builds.

## Test plan
- Single request, `i_req`=3'b100, `i_data[71:48]`=24'h78_40_A5, done 10 cycles after ISSUE:
  - `o_iic_req` pulses once with `o_iic_data`=24'h7840A5.
  - `o_grant`=3'b100 throughout.
  - `o_ack`=3'b100 for one cycle, one cycle after done.
- Simultaneous `i_req`=3'b111, requesters dropping on ack, fixed priority:
  - Service order is channel 0, 1, 2.
  - Three `o_iic_req` pulses in total, each carrying the matching channel's word.
- Same stimulus as the previous scenario with `OLED_ARB_RR_EN` defined and all channels re-requesting after ack:
  - Order is 0, 1, 2, 0, 1, 2. No channel is served twice in a row.
- Channel 0 raises `i_req` while channel 2 is in WAIT:
  - Channel 2 still completes and is acked.
  - Channel 0 is granted in the following IDLE cycle.
  - `o_iic_data` is unchanged until then.
- Stray `i_iic_done` pulses in IDLE and in ISSUE:
  - No state change and no `o_ack`.
  - The transfer completes only on the later done pulse in WAIT.
- `rst_n` asserted low during WAIT:
  - All outputs are 0 asynchronously. No `o_ack` is issued.
  - After release, a held `i_req`=3'b010 is granted, with ISSUE one cycle after IDLE.

Source files
------------

// File: rtl/oled_iic_arb_if.sv
// Bundle between the OLED command sources, the arbiter and the IIC engine.
// The slave modport is the arbiter side; the master modport is the sources/engine side.
interface oled_iic_arb_if #(
    parameter int N_CH = 3,
    parameter int DW   = 24
);
    logic [N_CH-1:0]    i_req;
    logic [N_CH*DW-1:0] i_data;
    logic [N_CH-1:0]    o_ack;
    logic [N_CH-1:0]    o_grant;
    logic               o_busy;
    logic               o_iic_req;
    logic [DW-1:0]      o_iic_data;
    logic               i_iic_done;

    modport slave (
        input  i_req, i_data, i_iic_done,
        output o_ack, o_grant, o_busy, o_iic_req, o_iic_data
    );

    modport master (
        output i_req, i_data, i_iic_done,
        input  o_ack, o_grant, o_busy, o_iic_req, o_iic_data
    );
endinterface

// File: rtl/oled_iic_arb.sv
// Grant-locked N-channel arbiter feeding one IIC byte-transfer engine.
// Define OLED_ARB_RR_EN for round-robin selection; default is fixed priority.
module oled_iic_arb #(
    parameter int N_CH = 3,
    parameter int DW   = 24
) (
    input  logic          clk_50m,
    input  logic          rst_n,
    oled_iic_arb_if.slave bus
);
    localparam int IW = $clog2(N_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   win;
    logic [N_CH-1:0] grant_q, grant_d;
    logic [N_CH-1:0] ack_q, ack_d;
    logic [DW-1:0]   data_q, data_d;
    logic            iic_req_q;
    logic            busy_q;

`ifdef OLED_ARB_RR_EN
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] idx_q;

    // Search begins just past the last served channel and wraps.
    always_comb begin
        win = '0;
        for (int off = N_CH; off >= 1; off--) begin
            if (bus.i_req[(int'(ptr_q) + off) % N_CH])
                win = IW'((int'(ptr_q) + off) % N_CH);
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IW'(N_CH - 1);
            idx_q <= '0;
        end else begin
            if (state_q == S_IDLE && |bus.i_req)
                idx_q <= win;
            if (state_q == S_ACK)
                ptr_q <= idx_q;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (bus.i_req[k])
                win = IW'(k);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        data_d  = data_q;
        ack_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.i_req) begin
                    state_d = S_ISSUE;
                    grant_d = N_CH'(1) << win;
                    data_d  = bus.i_data[int'(win)*DW +: DW];
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.i_iic_done) begin
                    state_d = S_ACK;
                    ack_d   = grant_q;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            data_q    <= '0;
            iic_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            iic_req_q <= (state_d == S_ISSUE);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign bus.o_ack      = ack_q;
    assign bus.o_grant    = grant_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_iic_req  = iic_req_q;
    assign bus.o_iic_data = data_q;
endmodule
